// File: rtl/spdif_pkg.sv
// Shared definitions for the S/PDIF frame scheduler: FSM encoding, block length,
// channel-status bit positions and the 24-bit word-length code.
package spdif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRIME    = 2'd1,
        ST_RUN      = 2'd2,
        ST_UNDERRUN = 2'd3
    } sched_state_t;

    localparam int          BLOCK_FRAMES = 192;
    localparam int          SAMPLE_W     = 24;
    localparam int          CS_COPY_BIT  = 2;
    localparam int          CS_SR_LSB    = 24;
    localparam int          CS_WL_LSB    = 32;
    localparam logic [3:0]  WORD_LEN_24  = 4'b1011;

endpackage

// File: rtl/spdif_sample_fifo.sv
// Synchronous stereo-pair FIFO with occupancy output; flush empties it in one cycle.
// Caller guarantees no push when full and no pop when empty.
module spdif_sample_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 48
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/spdif_frame_sched.sv
// S/PDIF frame scheduler: FIFO-buffered L/R release per frame request, 192-frame block
// tracking, channel-status and validity generation. Optional SPDIF_SCHED_UNDERRUN_CNT_EN adds underrun_cnt.
module spdif_frame_sched
    import spdif_pkg::*;
#(
    parameter int   DEPTH       = 8,
    parameter int   PRIME_LEVEL = 4,
    parameter logic COPY_OK     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [23:0]             s_left,
    input  logic [23:0]             s_right,
    input  logic [3:0]              sample_rate_code,
    input  logic                    frame_req,
    output logic [31:0]             data_left,
    output logic [31:0]             data_right,
    output logic                    validity,
    output logic                    cs_bit_left,
    output logic                    cs_bit_right,
    output logic                    block_start,
`ifdef SPDIF_SCHED_UNDERRUN_CNT_EN
    output logic [15:0]             underrun_cnt,
`endif
    output logic                    underrun,
    output logic [$clog2(DEPTH):0]  fifo_level
);
    localparam int LW = $clog2(DEPTH) + 1;

    sched_state_t              state, state_nxt;
    logic [2*SAMPLE_W-1:0]     rd_pair;
    logic                      push, pop, frame_load, underrun_evt;
    logic [7:0]                frame_idx;
    logic [3:0]                sr_blk;

    function automatic logic cs_bit(input logic [7:0] idx, input logic [3:0] sr);
        logic b;
        b = 1'b0;
        if (idx == 8'(CS_COPY_BIT))
            b = COPY_OK;
        else if (idx >= 8'(CS_SR_LSB) && idx < 8'(CS_SR_LSB + 4))
            b = sr[2'(idx - 8'(CS_SR_LSB))];
        else if (idx >= 8'(CS_WL_LSB) && idx < 8'(CS_WL_LSB + 4))
            b = WORD_LEN_24[2'(idx - 8'(CS_WL_LSB))];
        return b;
    endfunction

    assign s_ready      = (state != ST_IDLE) && (fifo_level < LW'(DEPTH));
    assign push         = s_valid && s_ready;
    assign frame_load   = frame_req && enable && (state != ST_IDLE);
    assign pop          = frame_load && (state == ST_RUN) && (fifo_level != '0);
    assign underrun_evt = frame_load && (state == ST_RUN) && (fifo_level == '0);

    spdif_sample_fifo #(.DEPTH(DEPTH), .DATA_W(2*SAMPLE_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (!enable),
        .push    (push),
        .pop     (pop),
        .wr_data ({s_left, s_right}),
        .rd_data (rd_pair),
        .level   (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     state_nxt = ST_PRIME;
            ST_PRIME:    if (fifo_level >= LW'(PRIME_LEVEL)) state_nxt = ST_RUN;
            ST_RUN:      if (underrun_evt) state_nxt = ST_UNDERRUN;
            ST_UNDERRUN: if (fifo_level >= LW'(PRIME_LEVEL)) state_nxt = ST_RUN;
            default:     state_nxt = ST_IDLE;
        endcase
        if (!enable) state_nxt = ST_IDLE;
    end

    // Block position; the rate code is captured at frame 0 so a block is self-consistent
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            frame_idx <= '0;
        end else if (frame_load) begin
            frame_idx <= (frame_idx == 8'(BLOCK_FRAMES - 1)) ? 8'd0 : frame_idx + 8'd1;
        end
        if (rst)
            sr_blk <= '0;
        else if (frame_load && frame_idx == 8'd0)
            sr_blk <= sample_rate_code;
    end

    // Output stage: loaded on frame request, held until the next one
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            data_left    <= '0;
            data_right   <= '0;
            validity     <= 1'b1;
            cs_bit_left  <= 1'b0;
            cs_bit_right <= 1'b0;
            block_start  <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            underrun <= underrun_evt;
            if (frame_load) begin
                if (pop) begin
                    data_left  <= {8'h00, rd_pair[2*SAMPLE_W-1:SAMPLE_W]};
                    data_right <= {8'h00, rd_pair[SAMPLE_W-1:0]};
                    validity   <= 1'b0;
                end else begin
                    data_left  <= '0;
                    data_right <= '0;
                    validity   <= 1'b1;
                end
                cs_bit_left  <= cs_bit(frame_idx, sr_blk);
                cs_bit_right <= cs_bit(frame_idx, sr_blk);
                block_start  <= (frame_idx == 8'd0);
            end
        end
    end

`ifdef SPDIF_SCHED_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            underrun_cnt <= '0;
        else if (underrun_evt && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_spdif_frame_sched.sv
// Directed self-checking bench for spdif_frame_sched (DEPTH=8, PRIME_LEVEL=4, COPY_OK=1).
module tb_spdif_frame_sched;
    logic        clk = 1'b0;
    logic        rst, enable, s_valid, s_ready, frame_req;
    logic [23:0] s_left, s_right;
    logic [3:0]  sample_rate_code;
    logic [31:0] data_left, data_right;
    logic        validity, cs_bit_left, cs_bit_right, block_start, underrun;
    logic [3:0]  fifo_level;
`ifdef SPDIF_SCHED_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spdif_frame_sched #(.DEPTH(8), .PRIME_LEVEL(4), .COPY_OK(1'b1)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_left           (s_left),
        .s_right          (s_right),
        .sample_rate_code (sample_rate_code),
        .frame_req        (frame_req),
        .data_left        (data_left),
        .data_right       (data_right),
        .validity         (validity),
        .cs_bit_left      (cs_bit_left),
        .cs_bit_right     (cs_bit_right),
        .block_start      (block_start),
`ifdef SPDIF_SCHED_UNDERRUN_CNT_EN
        .underrun_cnt     (underrun_cnt),
`endif
        .underrun         (underrun),
        .fifo_level       (fifo_level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pairs(input int n, input logic [23:0] l, input logic [23:0] r);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1; s_left = l; s_right = r;
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic frame();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
    endtask

    task automatic restart();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; s_valid = 1'b0; frame_req = 1'b0;
        s_left = '0; s_right = '0; sample_rate_code = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (data_left !== 32'h0 || data_right !== 32'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", data_left, data_right); end
        checks++; if (validity !== 1'b1) begin failures++; $display("FAIL reset_validity got=%b exp=1", validity); end
        checks++; if ({cs_bit_left, cs_bit_right, block_start, underrun} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {cs_bit_left, cs_bit_right, block_start, underrun}); end
    endtask

    task automatic test_first_frame();
        enable = 1'b1;
        tick();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL prime_s_ready got=%b exp=1", s_ready); end
        push_pairs(4, 24'h123456, 24'hABCDEF);
        checks++; if (fifo_level !== 4'd4) begin failures++; $display("FAIL prime_level got=%0d exp=4", fifo_level); end
        tick();
        frame();
        checks++; if (data_left !== 32'h00123456) begin failures++; $display("FAIL first_left got=%h exp=00123456", data_left); end
        checks++; if (data_right !== 32'h00ABCDEF) begin failures++; $display("FAIL first_right got=%h exp=00abcdef", data_right); end
        checks++; if (validity !== 1'b0) begin failures++; $display("FAIL first_validity got=%b exp=0", validity); end
        checks++; if (block_start !== 1'b1) begin failures++; $display("FAIL first_block_start got=%b exp=1", block_start); end
        checks++; if (fifo_level !== 4'd3) begin failures++; $display("FAIL first_level got=%0d exp=3", fifo_level); end
    endtask

    task automatic test_underrun();
        for (int i = 0; i < 3; i++) begin
            frame();
            checks++; if (validity !== 1'b0) begin failures++; $display("FAIL drain_validity frame=%0d got=%b exp=0", i, validity); end
        end
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL drain_level got=%0d exp=0", fifo_level); end
        frame();
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_pulse got=%b exp=1", underrun); end
        checks++; if (data_left !== 32'h0 || data_right !== 32'h0) begin failures++; $display("FAIL underrun_data got=%h/%h exp=0/0", data_left, data_right); end
        checks++; if (validity !== 1'b1) begin failures++; $display("FAIL underrun_validity got=%b exp=1", validity); end
        tick();
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_one_cycle got=%b exp=0", underrun); end
        frame();
        checks++; if (underrun !== 1'b0 || validity !== 1'b1) begin failures++; $display("FAIL underrun_state_frame got=%b/%b exp=0/1", underrun, validity); end
        push_pairs(4, 24'h800000, 24'h7FFFFF);
        tick();
        frame();
        checks++; if (data_left !== 32'h00800000 || data_right !== 32'h007FFFFF) begin failures++; $display("FAIL refill_data got=%h/%h exp=00800000/007fffff", data_left, data_right); end
        checks++; if (validity !== 1'b0) begin failures++; $display("FAIL refill_validity got=%b exp=0", validity); end
    endtask

    task automatic test_block_wrap();
        logic exp_bs;
        restart();
        push_pairs(4, 24'h000100, 24'h000200);
        tick();
        for (int f = 0; f < 384; f++) begin
            s_valid = 1'b1; s_left = 24'(f); s_right = 24'(f);
            frame_req = 1'b1;
            tick();
            s_valid = 1'b0; frame_req = 1'b0;
            exp_bs = (f == 0) || (f == 192);
            checks++; if (block_start !== exp_bs || validity !== 1'b0) begin failures++; $display("FAIL block_frame f=%0d bs=%b exp_bs=%b validity=%b exp=0", f, block_start, exp_bs, validity); end
        end
        checks++; if (fifo_level !== 4'd4) begin failures++; $display("FAIL block_level got=%0d exp=4", fifo_level); end
    endtask

    task automatic test_channel_status();
        logic exp_cs;
        restart();
        sample_rate_code = 4'b1110;
        push_pairs(4, 24'h000001, 24'h000002);
        tick();
        for (int f = 0; f < 40; f++) begin
            if (f == 10) sample_rate_code = 4'b0000;
            s_valid = 1'b1;
            frame_req = 1'b1;
            tick();
            s_valid = 1'b0; frame_req = 1'b0;
            exp_cs = (f == 2) || (f == 25) || (f == 26) || (f == 27) || (f == 32) || (f == 33) || (f == 35);
            checks++; if (cs_bit_left !== exp_cs || cs_bit_right !== exp_cs) begin failures++; $display("FAIL cs_frame f=%0d got=%b/%b exp=%b", f, cs_bit_left, cs_bit_right, exp_cs); end
        end
    endtask

    task automatic test_full();
        push_pairs(4, 24'h0F0F0F, 24'hF0F0F0);
        checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL full_level got=%0d exp=8", fifo_level); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL full_s_ready got=%b exp=0", s_ready); end
        s_valid = 1'b1; frame_req = 1'b1;
        tick();
        s_valid = 1'b0; frame_req = 1'b0;
        checks++; if (fifo_level !== 4'd7) begin failures++; $display("FAIL full_push_pop_level got=%0d exp=7", fifo_level); end
        checks++; if (s_ready !== 1'b1 || validity !== 1'b0) begin failures++; $display("FAIL full_after_pop got=%b/%b exp=1/0", s_ready, validity); end
    endtask

    task automatic test_enable_drop();
        enable = 1'b0;
        tick();
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL drop_level got=%0d exp=0", fifo_level); end
        checks++; if (validity !== 1'b1 || data_left !== 32'h0 || s_ready !== 1'b0) begin failures++; $display("FAIL drop_outputs got=%b/%h/%b exp=1/0/0", validity, data_left, s_ready); end
        enable = 1'b1;
        tick();
        push_pairs(4, 24'h654321, 24'h111111);
        tick();
        frame();
        checks++; if (block_start !== 1'b1 || validity !== 1'b0) begin failures++; $display("FAIL reenable_frame got=%b/%b exp=1/0", block_start, validity); end
        checks++; if (data_left !== 32'h00654321) begin failures++; $display("FAIL reenable_data got=%h exp=00654321", data_left); end
    endtask

`ifdef SPDIF_SCHED_UNDERRUN_CNT_EN
    task automatic test_underrun_cnt();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (underrun_cnt !== 16'd0) begin failures++; $display("FAIL cnt_reset got=%0d exp=0", underrun_cnt); end
        enable = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            push_pairs(4, 24'h000003, 24'h000004);
            tick();
            for (int i = 0; i < 5; i++) frame();
        end
        checks++; if (underrun_cnt !== 16'd3) begin failures++; $display("FAIL cnt_three got=%0d exp=3", underrun_cnt); end
        enable = 1'b0;
        tick();
        checks++; if (underrun_cnt !== 16'd3) begin failures++; $display("FAIL cnt_enable_hold got=%0d exp=3", underrun_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_frame();
        test_underrun();
        test_block_wrap();
        test_channel_status();
        test_full();
        test_enable_drop();
`ifdef SPDIF_SCHED_UNDERRUN_CNT_EN
        test_underrun_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
